// File: rtl/instruction_fetch.sv
// Instruction fetch stage: holds pc and the instruction register, requests words
// from instruction memory and computes the next pc on retirement.
module instruction_fetch #(
    parameter logic [31:0]  RESET_PC = 32'h0000_0000,
    localparam int unsigned XLEN     = 32,
    localparam int unsigned WLEN     = XLEN - 2,
    localparam int unsigned OPW      = 6,
    localparam int unsigned REGW     = 5,
    localparam int unsigned IMMW     = 16
) (
    input  logic             CLOCK_50,
    input  logic             Reset,
    input  logic             Run,
    input  logic             pc_write,
    input  logic             Pcsrc,
    input  logic             jump,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [XLEN-1:0]  imem_rdata,
    input  logic             imem_valid,
    output logic             instr_valid,
    output logic [OPW-1:0]   opcode,
    output logic [OPW-1:0]   funct,
    output logic [REGW-1:0]  rs,
    output logic [REGW-1:0]  rt,
    output logic [REGW-1:0]  rd,
    output logic [REGW-1:0]  shamt,
    output logic [IMMW-1:0]  imm,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic [XLEN-1:0]  fetch_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic [OPW-1:0]  opcode;
        logic [REGW-1:0] rs;
        logic [REGW-1:0] rt;
        logic [REGW-1:0] rd;
        logic [REGW-1:0] shamt;
        logic [OPW-1:0]  funct;
    } instr_t;

    state_t            state_q;
    state_t            state_d;
    instr_t            ir_q;
    logic [WLEN-1:0]   pc_q;
    logic              valid_q;
    logic [XLEN-1:0]   count_q;

    logic              load_en;
    logic              retire_en;
    logic [WLEN-1:0]   pc_inc_w;
    logic [WLEN-1:0]   branch_w;
    logic [WLEN-1:0]   jump_w;
    logic [WLEN-1:0]   next_pc_w;
    logic [IMMW-1:0]   imm_w;

    // pc is kept as a word address so its two low bits can never be nonzero
    assign pc_inc_w  = pc_q + WLEN'(1);
    assign imm_w     = {ir_q.rd, ir_q.shamt, ir_q.funct};
    assign branch_w  = pc_inc_w + WLEN'({{(WLEN-IMMW){imm_w[IMMW-1]}}, imm_w});
    assign jump_w    = {pc_inc_w[WLEN-1:WLEN-4], ir_q[WLEN-5:0]};
    assign next_pc_w = jump  ? jump_w   :
                       Pcsrc ? branch_w :
                               pc_inc_w;

    // State register
    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Run)        state_d = FETCH;
            FETCH:   if (imem_valid) state_d = HOLD;
            HOLD:    if (pc_write)   state_d = Run ? FETCH : IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // State-decoded outputs and datapath strobes
    always_comb begin
        imem_req  = 1'b0;
        load_en   = 1'b0;
        retire_en = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                load_en  = imem_valid;
            end
            HOLD:    retire_en = pc_write;
            default: ;
        endcase
    end

    // pc, instruction register, valid flag and fetch counter
    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            pc_q    <= RESET_PC[XLEN-1:2];
            ir_q    <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            if (load_en) begin
                ir_q    <= instr_t'(imem_rdata);
                valid_q <= 1'b1;
                count_q <= count_q + XLEN'(1);
            end
            if (retire_en) begin
                pc_q    <= next_pc_w;
                valid_q <= 1'b0;
            end
        end
    end

    assign imem_addr   = {pc_q, 2'b00};
    assign pc          = {pc_q, 2'b00};
    assign pc_plus4    = {pc_inc_w, 2'b00};
    assign instr_valid = valid_q;
    assign fetch_count = count_q;

    // Decoded fields are pure slices of the registered instruction
    assign opcode = ir_q.opcode;
    assign rs     = ir_q.rs;
    assign rt     = ir_q.rt;
    assign rd     = ir_q.rd;
    assign shamt  = ir_q.shamt;
    assign funct  = ir_q.funct;
    assign imm    = imm_w;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed plus randomized bench for instruction_fetch with a transaction-level
// reference model of pc, instruction register and fetch count.
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic        pc_write;
    logic        pcsrc;
    logic        jump;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        instr_valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] fetch_count;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] e_pc;
    logic [31:0] e_ir;
    logic [31:0] e_cnt;

    instruction_fetch #(.RESET_PC(RST_PC)) dut (
        .CLOCK_50   (clk),
        .Reset      (reset_n),
        .Run        (run),
        .pc_write   (pc_write),
        .Pcsrc      (pcsrc),
        .jump       (jump),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .instr_valid(instr_valid),
        .opcode     (opcode),
        .funct      (funct),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .shamt      (shamt),
        .imm        (imm),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare every architectural output against the model
    task automatic check_ir(input string tag);
        check({tag, ".valid"},  32'(instr_valid), 32'd1);
        check({tag, ".opcode"}, 32'(opcode), e_ir >> 26);
        check({tag, ".rs"},     32'(rs),     (e_ir >> 21) & 32'h1F);
        check({tag, ".rt"},     32'(rt),     (e_ir >> 16) & 32'h1F);
        check({tag, ".rd"},     32'(rd),     (e_ir >> 11) & 32'h1F);
        check({tag, ".shamt"},  32'(shamt),  (e_ir >> 6) & 32'h1F);
        check({tag, ".funct"},  32'(funct),  e_ir & 32'h3F);
        check({tag, ".imm"},    32'(imm),    e_ir & 32'hFFFF);
        check({tag, ".pc"},     pc,          e_pc);
        check({tag, ".pc4"},    pc_plus4,    e_pc + 32'd4);
        check({tag, ".cnt"},    fetch_count, e_cnt);
    endtask

    task automatic wait_req();
        int budget = 20;
        while (imem_req !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        check("req_seen", 32'(imem_req), 32'd1);
    endtask

    // One fetch with 'waits' stall cycles; Run drops in stall cycle drop_at
    task automatic do_fetch(input logic [31:0] word, input int waits, input int drop_at);
        wait_req();
        check("fetch.addr", imem_addr, e_pc);
        for (int w = 0; w < waits; w++) begin
            imem_valid = 1'b0;
            imem_rdata = $urandom;
            pc_write   = 1'($urandom);
            jump       = 1'($urandom);
            pcsrc      = 1'($urandom);
            if (w == drop_at) run = 1'b0;
            tick();
            check("wait.addr",  imem_addr, e_pc);
            check("wait.req",   32'(imem_req), 32'd1);
            check("wait.valid", 32'(instr_valid), 32'd0);
            check("wait.pc",    pc, e_pc);
        end
        imem_valid = 1'b1;
        imem_rdata = word;
        tick();
        imem_valid = 1'b0;
        imem_rdata = $urandom;
        pc_write   = 1'b0;
        jump       = 1'b0;
        pcsrc      = 1'b0;
        e_ir  = word;
        e_cnt = e_cnt + 32'd1;
        check_ir("load");
        check("load.req", 32'(imem_req), 32'd0);
    endtask

    // Hold for 'stalls' cycles, then retire with the given jump/branch/run
    task automatic retire(input bit j, input bit b, input bit r, input int stalls);
        logic [31:0] ppc4;
        logic [31:0] nxt;
        int          off;
        for (int s = 0; s < stalls; s++) begin
            pc_write   = 1'b0;
            jump       = 1'($urandom);
            pcsrc      = 1'($urandom);
            imem_valid = 1'($urandom);
            imem_rdata = $urandom;
            tick();
            check("hold.req", 32'(imem_req), 32'd0);
            check("hold.ir",  {opcode, rs, rt, rd, shamt, funct}, e_ir);
            check("hold.pc",  pc, e_pc);
        end
        ppc4 = e_pc + 32'd4;
        off  = int'($signed(e_ir[15:0]));
        if (j)      nxt = (ppc4 & 32'hF000_0000) | ((e_ir & 32'h03FF_FFFF) << 2);
        else if (b) nxt = ppc4 + 32'(off * 4);
        else        nxt = ppc4;
        pc_write   = 1'b1;
        jump       = j;
        pcsrc      = b;
        run        = r;
        imem_valid = 1'b0;
        tick();
        pc_write = 1'b0;
        jump     = 1'b0;
        pcsrc    = 1'b0;
        e_pc     = nxt;
        check("retire.valid", 32'(instr_valid), 32'd0);
        check("retire.pc",    pc, nxt);
        check("retire.req",   32'(imem_req), 32'(r));
        if (!r) begin
            imem_valid = 1'b1;
            imem_rdata = $urandom;
            repeat (2) tick();
            imem_valid = 1'b0;
            check("idle.req",   32'(imem_req), 32'd0);
            check("idle.valid", 32'(instr_valid), 32'd0);
            check("idle.cnt",   fetch_count, e_cnt);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        run        = 1'b0;
        pc_write   = 1'b0;
        pcsrc      = 1'b0;
        jump       = 1'b0;
        imem_valid = 1'b0;
        imem_rdata = 32'd0;
        e_pc  = RST_PC;
        e_ir  = 32'd0;
        e_cnt = 32'd0;

        // Reset state before any clock edge
        #3;
        check("rst.req",    32'(imem_req), 32'd0);
        check("rst.pc",     pc, RST_PC);
        check("rst.valid",  32'(instr_valid), 32'd0);
        check("rst.cnt",    fetch_count, 32'd0);
        check("rst.opcode", 32'(opcode), 32'd0);

        // First request one cycle after the first edge following release
        tick();
        reset_n = 1'b1;
        run     = 1'b1;
        check("rel.req0", 32'(imem_req), 32'd0);
        tick();
        check("rel.req1", 32'(imem_req), 32'd1);
        check("rel.addr", imem_addr, RST_PC);

        // Sequential stream of add instructions
        for (int i = 0; i < 3; i++) begin
            check("seq.pc", pc, 32'(i * 4));
            do_fetch(32'h0000_0020, 0, -1);
            retire(1'b0, 1'b0, 1'b1, 1);
        end
        check("seq.cnt", fetch_count, 32'd3);

        // Branch taken and not taken from pc 0x10
        do_fetch($urandom, 0, -1);
        retire(1'b0, 1'b0, 1'b1, 0);
        check("br.start", imem_addr, 32'h10);
        do_fetch(32'h1000_FFFE, 0, -1);
        retire(1'b0, 1'b1, 1'b1, 2);
        check("br.taken", imem_addr, 32'h0C);
        do_fetch($urandom, 1, -1);
        retire(1'b0, 1'b0, 1'b1, 0);
        do_fetch(32'h1000_FFFE, 0, -1);
        retire(1'b0, 1'b0, 1'b1, 0);
        check("br.nt", imem_addr, 32'h14);

        // Reach 0x1000_0000 via jump then sequential step; then jump beats branch
        do_fetch(32'h0BFF_FFFF, 0, -1);
        retire(1'b1, 1'b0, 1'b1, 0);
        check("j.far", imem_addr, 32'h0FFF_FFFC);
        do_fetch($urandom, 0, -1);
        retire(1'b0, 1'b0, 1'b1, 0);
        check("j.base", imem_addr, 32'h1000_0000);
        do_fetch(32'h0800_0040, 0, -1);
        retire(1'b1, 1'b1, 1'b1, 1);
        check("j.prio", imem_addr, 32'h1000_0100);

        // Wait states with Run dropped mid-fetch, then retire to IDLE
        do_fetch($urandom, 3, 1);
        retire(1'b0, 1'b0, 1'b0, 1);

        // Asynchronous reset between edges during FETCH
        run = 1'b1;
        wait_req();
        #2;
        reset_n = 1'b0;
        #1;
        check("arst.req",   32'(imem_req), 32'd0);
        check("arst.pc",    pc, RST_PC);
        check("arst.valid", 32'(instr_valid), 32'd0);
        check("arst.cnt",   fetch_count, 32'd0);
        imem_valid = 1'b1;
        imem_rdata = $urandom;
        tick();
        tick();
        reset_n = 1'b1;
        run     = 1'b0;
        tick();
        check("arst.late_valid", 32'(instr_valid), 32'd0);
        check("arst.late_req",   32'(imem_req), 32'd0);
        tick();
        imem_valid = 1'b0;
        check("arst.ir",   {opcode, rs, rt, rd, shamt, funct}, 32'd0);
        check("arst.cnt2", fetch_count, 32'd0);
        e_pc  = RST_PC;
        e_ir  = 32'd0;
        e_cnt = 32'd0;

        // Backward branch from 0 lands at the top of memory, then wraps
        run = 1'b1;
        do_fetch(32'h1000_FFFE, 0, -1);
        retire(1'b0, 1'b1, 1'b1, 0);
        check("wrap.top", imem_addr, 32'hFFFF_FFFC);
        do_fetch($urandom, 0, -1);
        retire(1'b0, 1'b0, 1'b1, 0);
        check("wrap.zero", imem_addr, 32'h0000_0000);

        // Randomized fetch/retire traffic
        for (int i = 0; i < 40; i++) begin
            run = 1'b1;
            do_fetch($urandom, $urandom_range(0, 3), -1);
            retire(1'($urandom), 1'($urandom), $urandom_range(0, 7) != 0,
                   $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
